// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. Requester 0 is the
//   EX-stage issue path and requester 1 is the multi-cycle helper path.
//   In each cycle at most one requester is granted. The grant drives the ALU
//   operand and control lines, and the next clock edge captures the ALU output
//   into that requester's response slot.
//
//   Build option:
//     ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie and no
//                                         pointer register is built
//                            undefined -> round-robin tie-break (default)
//
//   Ports:
//     clk, reset_n                 clock (rising edge) and async active-low reset
//     req{0,1}_valid/ready         request handshake
//     req{0,1}_op/a/b              ALU control code and signed operands
//     rsp{0,1}_valid/ready         response handshake
//     rsp{0,1}_result/zero         captured ALU result and zero flag
//     alu_a, alu_b, alu_ctrl       drive to the shared ALU
//     alu_result, alu_zero         return from the shared ALU
//     busy                         a grant is active or a response slot is occupied
//
//   Tie-break pointer (round-robin build only):
//     state    | meaning
//     PRI_REQ0 | requester 0 wins when both are eligible
//     PRI_REQ1 | requester 1 wins when both are eligible
module alu_arbiter #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] IDLE_OP = 4'b0010
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             busy
);

  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;

  // A full slot that is drained in this cycle can be refilled in the same cycle.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // While reset is asserted, the grant is forced off so the ALU bus returns to idle
  // immediately and does not wait for a clock edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      gnt0 = elig0;
      gnt1 = elig1 & ~elig0;
    end
  end

`else

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_t;

  pri_t pri_q;
  pri_t pri_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri_q <= PRI_REQ0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // After each grant, priority moves to the requester that was not granted.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pri_d = pri_q;
    if (reset_n) begin
      if (elig0 && elig1) begin
        if (pri_q == PRI_REQ0) gnt0 = 1'b1;
        else                   gnt1 = 1'b1;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
      if (gnt0)      pri_d = PRI_REQ1;
      else if (gnt1) pri_d = PRI_REQ0;
    end
  end

`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = IDLE_OP;
    if (gnt0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_op;
    end else if (gnt1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_op;
    end
  end

  // Response slot 0. A refill takes precedence over a drain, so valid stays
  // high and there is no bubble between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (gnt0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_zero   <= alu_zero;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Response slot 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (gnt1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_zero   <= alu_zero;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

  assign busy = gnt0 | gnt1 | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int         WIDTH   = 32;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0] rsp1_result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .IDLE_OP(OP_ADD)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Reference combinational ALU sitting on the shared bus.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_MUL:  alu_result = alu_a * alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_op = OP_AND; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = OP_AND; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    check("rst_rsp0_valid",  rsp0_valid,  0);
    check("rst_rsp1_valid",  rsp1_valid,  0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_rsp1_zero",   rsp1_zero,   0);
    check("rst_busy",        busy,        0);
    check("rst_alu_ctrl",    alu_ctrl,    OP_ADD);
    check("rst_alu_a",       alu_a,       0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Single request: 5 + 7.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 5; req0_b = 7; rsp0_ready = 1'b1;
    #1;
    check("single_req0_ready", req0_ready, 1);
    check("single_alu_a",      alu_a,      5);
    check("single_alu_b",      alu_b,      7);
    check("single_busy",       busy,       1);
    step();
    req0_valid = 1'b0;
    check("single_rsp0_valid",  rsp0_valid,  1);
    check("single_rsp0_result", rsp0_result, 12);
    check("single_rsp0_zero",   rsp0_zero,   0);
    step();
    check("single_rsp0_clear", rsp0_valid, 0);

    // Lone requester 1: 1 + 2.
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 1; req1_b = 2; rsp1_ready = 1'b1;
    #1;
    check("lone1_req1_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    check("lone1_rsp1_result", rsp1_result, 3);
    step();

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Contention: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 9;     req0_b = 9;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 'hF0;  req1_b = 'h0F;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
      step();
      if (k % 2 == 0) begin
        check("rr_rsp0_valid",  rsp0_valid,  1);
        check("rr_rsp0_result", rsp0_result, 0);
        check("rr_rsp0_zero",   rsp0_zero,   1);
      end else begin
        check("rr_rsp1_valid",  rsp1_valid,  1);
        check("rr_rsp1_result", rsp1_result, 'hFF);
        check("rr_rsp1_zero",   rsp1_zero,   0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    check("rr_drained0", rsp0_valid, 0);
    check("rr_drained1", rsp1_valid, 0);
`endif

    // Backpressure on slot 0: slt -1 < 1.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_SLT; req0_a = 32'hFFFF_FFFF; req0_b = 1;
    #1;
    check("bp_first_grant", req0_ready, 1);
    step();
    req0_op = OP_ADD; req0_a = 2; req0_b = 2;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 10; req1_b = 20;
    check("bp_rsp0_valid",  rsp0_valid,  1);
    check("bp_rsp0_result", rsp0_result, 1);
    #1;
    check("bp_req0_blocked", req0_ready, 0);
    check("bp_req1_served",  req1_ready, 1);
    step();
    req1_valid = 1'b0;
    check("bp_rsp0_hold",   rsp0_result, 1);
    check("bp_rsp1_result", rsp1_result, 30);
    #1;
    check("bp_req0_still_blocked", req0_ready, 0);
    #1;
    rsp0_ready = 1'b1;
    #1;
    check("bp_req0_released", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check("bp_refill_valid",  rsp0_valid,  1);
    check("bp_refill_result", rsp0_result, 4);
    step();
    check("bp_clear", rsp0_valid, 0);

    // Drain and refill back to back: 3 * -4.
    req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 3; req0_b = 32'hFFFF_FFFC;
    for (int k = 0; k < 4; k++) begin
      step();
      check("dr_rsp0_valid",  rsp0_valid,  1);
      check("dr_rsp0_result", rsp0_result, 32'hFFFF_FFF4);
    end
    req0_valid = 1'b0;
    step();
    check("dr_clear", rsp0_valid, 0);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Priority now points at requester 1. Reset is asserted mid-grant.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 1;  req0_b = 1;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 50; req1_b = 8;
    #1;
    check("ar_a_req1_ready", req1_ready, 1);
    step();
    check("ar_a_rsp1_result", rsp1_result, 42);
    #1;
    check("ar_b_req0_ready", req0_ready, 1);
    step();
    #1;
    check("ar_c_req1_ready", req1_ready, 1);
    check("ar_c_alu_ctrl",   alu_ctrl,   OP_SUB);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_rsp0_valid", rsp0_valid, 0);
    check("ar_rsp1_valid", rsp1_valid, 0);
    check("ar_alu_ctrl",   alu_ctrl,   OP_ADD);
    check("ar_alu_a",      alu_a,      0);
    check("ar_busy",       busy,       0);
    check("ar_req1_ready", req1_ready, 0);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ar_post_req0_ready", req0_ready, 1);
    check("ar_post_req1_ready", req1_ready, 0);
    step();
    check("ar_post_rsp0_valid",  rsp0_valid,  1);
    check("ar_post_rsp0_result", rsp0_result, 2);
    check("ar_post_rsp1_valid",  rsp1_valid,  0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
`else
    // Fixed priority: requester 0 wins every tie.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 1;  req0_b = 1;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 50; req1_b = 8;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fp_req0_ready", req0_ready, 1);
      check("fp_req1_ready", req1_ready, 0);
      step();
    end
    req0_valid = 1'b0;
    #1;
    check("fp_req1_after_drop", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    check("fp_rsp1_result", rsp1_result, 42);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
